square_tone_oscillator: RTL
===========================

# square_tone_oscillator

Per-voice square-wave tone generator sitting directly downstream of the MIDI note-number-to-sample-ticks lookup. It latches the looked-up half-period (in audio sample ticks) and velocity on a note-on event, then produces one signed PCM sample per audio sample strobe. Amplitude follows a linear attack/sustain/release envelope. Output feeds the codec sample mixer.

## Interface
- ATTACK_STEP, 64: amplitude increment per sample strobe in ATTACK
- RELEASE_STEP, 16: amplitude decrement per sample strobe in RELEASE
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- sampleStrobe  in  1  single-cycle pulse, one per audio sample
- noteOn  in  1  single-cycle pulse; latches noteSampleTicks and velocity
- noteOff  in  1  single-cycle pulse; starts release
- noteSampleTicks  in  24  half-period in sample strobes, from the lookup
- velocity  in  7  MIDI velocity
- sampleOut  out  16  signed two's-complement sample
- sampleValid  out  1  pulses one cycle after each sampleStrobe
- busy  out  1  high when state != IDLE

## Operation
- Registers: halfTicks[23:0], counter[23:0], phase (1 = positive), amp[14:0] unsigned, target[14:0] = {velocity, 8'b0} (max 32512).
- States: IDLE, ATTACK, SUSTAIN, RELEASE.
- noteOn with noteSampleTicks != 0: latch halfTicks, target; counter <- 0; phase unchanged (no click on retrigger); state <- ATTACK from current amp. noteOn with noteSampleTicks == 0: ignored entirely.
- noteOff: ATTACK/SUSTAIN -> RELEASE; ignored in IDLE or RELEASE.
- noteOn and noteOff in same cycle: noteOn wins, noteOff dropped.
- Per sampleStrobe (state != IDLE), in order: sampleOut <- phase ? +amp : -amp (using pre-update amp/phase); then counter += 1, and if counter == halfTicks-1: counter <- 0, phase toggles.
- Envelope per strobe: ATTACK: amp <- min(amp+ATTACK_STEP, target), and if amp already >= target, amp <- target; on reaching target -> SUSTAIN. SUSTAIN: hold. RELEASE: amp <- max(amp-RELEASE_STEP, 0); on reaching 0 -> IDLE, phase <- 0, counter <- 0.
- IDLE: strobes produce sampleOut = 0 with sampleValid.
- Event and strobe in the same cycle: sampleOut for that strobe uses pre-event state; event writes to counter/state/amp/halfTicks override strobe writes.
- All arithmetic saturating; no wrap of amp. counter never exceeds halfTicks-1.

## Timing
- Reset values: sampleOut = 0, sampleValid = 0, busy = 0; state IDLE, amp = 0, phase = 0, counter = 0, halfTicks = 0, target = 0.
- sampleValid: asserted exactly the cycle after sampleStrobe, one cycle wide; sampleOut stable from then until next update.
- busy: high the cycle after accepted noteOn; low the cycle after the strobe that drives amp to 0 in RELEASE.
- Latency noteOn -> first affected sampleOut: next strobe after the noteOn cycle.
- Reset asserted mid-note: immediate return to reset values; no sample emitted.
- Back-to-back strobes (every cycle) supported.

## Configuration
- TONE_ENVELOPE_EN defined: ATTACK and RELEASE ramps as above.
- Undefined: noteOn sets amp <- target and state <- SUSTAIN in the same cycle; noteOff sets amp <- 0, phase <- 0, counter <- 0, state <- IDLE immediately. ATTACK_STEP/RELEASE_STEP unused. RELEASE state never entered.

## Test plan
- Reset, 4 strobes, no note -> four sampleValid pulses, sampleOut = 0, busy = 0.
- Macro off, noteOn ticks=3 vel=1, 6 strobes -> sampleOut -256,-256,-256,+256,+256,+256; busy = 1.
- Macro on, noteOn ticks=3 vel=1, 5 strobes -> 0,-64,-128,+192,+256; SUSTAIN after strobe 4.
- Macro on, from SUSTAIN amp=256, noteOff, 16 strobes -> |sampleOut| 256,240,...,16; busy drops after 16th strobe; next strobe gives 0.
- noteOn ticks=0 while IDLE -> no state change, busy stays 0; noteOn and noteOff same cycle -> ATTACK entered.
- Retrigger in SUSTAIN vel=127 -> amp ramps from 256 toward 32512 by 64/strobe, phase unchanged, counter restarts at 0; rst_n low mid-note -> all outputs 0 immediately.

Source files
------------

// File: rtl/square_tone_oscillator.sv
// square_tone_oscillator
// Per-voice square-wave tone generator. A noteOn latches the half-period
// (in sample strobes) and velocity-derived target amplitude; each
// sampleStrobe emits one signed PCM sample on the following cycle.
// Optional feature macro: TONE_ENVELOPE_EN enables linear attack/release
// ramps. Without it, notes switch straight to full target amplitude on
// noteOn and to silence on noteOff.
module square_tone_oscillator #(
    parameter int unsigned ATTACK_STEP  = 32'd64,
    parameter int unsigned RELEASE_STEP = 32'd16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sampleStrobe,
    input  logic        noteOn,
    input  logic        noteOff,
    input  logic [23:0] noteSampleTicks,
    input  logic [6:0]  velocity,
    output logic [15:0] sampleOut,
    output logic        sampleValid,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t      state_r, state_next_s;
    logic [23:0] half_ticks_r, half_ticks_next_s;
    logic [23:0] counter_r, counter_next_s;
    logic        phase_r, phase_next_s;
    logic [14:0] amp_r, amp_next_s;
    logic [14:0] target_r, target_next_s;
    logic [15:0] sample_out_r, sample_out_next_s;
    logic        sample_valid_r, sample_valid_next_s;
    logic        busy_r, busy_next_s;
    logic        note_on_ok_s;
    logic        note_off_ok_s;

`ifdef TONE_ENVELOPE_EN
    // One bit of headroom so amp + step can never wrap before clamping.
    logic [15:0] amp_up_s;
    assign amp_up_s = {1'b0, amp_r} + ATTACK_STEP[15:0];
`else
    // Step sizes only matter for the ramped envelope.
    logic [31:0] unused_params_s;
    assign unused_params_s = ATTACK_STEP ^ RELEASE_STEP;
`endif

    assign note_on_ok_s  = noteOn && (noteSampleTicks != 24'd0);
    assign note_off_ok_s = noteOff && ((state_r == ATTACK) || (state_r == SUSTAIN));

    // Next-state logic: strobe updates first, then note events override them.
    always_comb begin
        state_next_s        = state_r;
        half_ticks_next_s   = half_ticks_r;
        counter_next_s      = counter_r;
        phase_next_s        = phase_r;
        amp_next_s          = amp_r;
        target_next_s       = target_r;
        sample_out_next_s   = sample_out_r;
        sample_valid_next_s = 1'b0;

        if (sampleStrobe) begin
            sample_valid_next_s = 1'b1;
            if (state_r == IDLE) begin
                sample_out_next_s = 16'd0;
            end else begin
                // Output uses the amplitude/phase from before this strobe.
                sample_out_next_s = phase_r ? {1'b0, amp_r} : (16'd0 - {1'b0, amp_r});
                // >= keeps the counter bounded even if halfTicks shrank.
                if (counter_r >= (half_ticks_r - 24'd1)) begin
                    counter_next_s = 24'd0;
                    phase_next_s   = ~phase_r;
                end else begin
                    counter_next_s = counter_r + 24'd1;
                end
`ifdef TONE_ENVELOPE_EN
                case (state_r)
                    ATTACK: begin
                        if ((amp_r >= target_r) || (amp_up_s >= {1'b0, target_r})) begin
                            amp_next_s   = target_r;
                            state_next_s = SUSTAIN;
                        end else begin
                            amp_next_s = amp_up_s[14:0];
                        end
                    end
                    RELEASE: begin
                        if (amp_r <= RELEASE_STEP[14:0]) begin
                            amp_next_s     = 15'd0;
                            state_next_s   = IDLE;
                            phase_next_s   = 1'b0;
                            counter_next_s = 24'd0;
                        end else begin
                            amp_next_s = amp_r - RELEASE_STEP[14:0];
                        end
                    end
                    default: begin
                        amp_next_s = amp_r;
                    end
                endcase
`endif
            end
        end else begin
            sample_valid_next_s = 1'b0;
        end

        // noteOn takes priority over a simultaneous noteOff; phase is left
        // alone on retrigger so the waveform does not click.
        if (note_on_ok_s) begin
            half_ticks_next_s = noteSampleTicks;
            target_next_s     = {velocity, 8'd0};
            counter_next_s    = 24'd0;
`ifdef TONE_ENVELOPE_EN
            amp_next_s        = amp_r;
            state_next_s      = ATTACK;
`else
            amp_next_s        = {velocity, 8'd0};
            state_next_s      = SUSTAIN;
`endif
        end else if (note_off_ok_s) begin
`ifdef TONE_ENVELOPE_EN
            state_next_s   = RELEASE;
`else
            amp_next_s     = 15'd0;
            phase_next_s   = 1'b0;
            counter_next_s = 24'd0;
            state_next_s   = IDLE;
`endif
        end else begin
            state_next_s = state_next_s;
        end

        busy_next_s = (state_next_s != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            half_ticks_r   <= 24'd0;
            counter_r      <= 24'd0;
            phase_r        <= 1'b0;
            amp_r          <= 15'd0;
            target_r       <= 15'd0;
            sample_out_r   <= 16'd0;
            sample_valid_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            half_ticks_r   <= half_ticks_next_s;
            counter_r      <= counter_next_s;
            phase_r        <= phase_next_s;
            amp_r          <= amp_next_s;
            target_r       <= target_next_s;
            sample_out_r   <= sample_out_next_s;
            sample_valid_r <= sample_valid_next_s;
            busy_r         <= busy_next_s;
        end
    end

    assign sampleOut   = sample_out_r;
    assign sampleValid = sample_valid_r;
    assign busy        = busy_r;

endmodule
